// File: rtl/fetch_stage.sv
// fetch_stage: PC register, redirect selection and the IF/ID pipeline register.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined;
// otherwise StallCount/FlushCount are tied to zero and no counter flops exist.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCWrPendingF,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [2:0]  TypeD,
    output logic [3:0]  OpD,
    output logic [4:0]  RegWriteAddressD,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    logic            redirect;
    logic [XLEN-1:0] redirectTarget;
    logic [XLEN-1:0] pcPlus4F;
    logic [XLEN-1:0] pcNext;
    logic            pcHold;
    logic            bubbleD;

    // Redirect detection; a resolved Execute branch outranks a Writeback PC write
    always_comb begin
        redirect       = BranchTakenE | PCSrcW;
        redirectTarget = BranchTakenE ? BranchTargetE : ResultW;
    end

    // Sequential fetch address, wraps naturally at the top of the address space
    assign pcPlus4F = PCF + XLEN'(4);

    // Next-PC select: redirect overrides both hazard holds
    always_comb begin
        pcHold = StallF | PCWrPendingF;
        pcNext = pcPlus4F;
        if (redirect) begin
            pcNext = redirectTarget;
        end else if (pcHold) begin
            pcNext = PCF;
        end
    end

    // PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= pcNext;
        end
    end

    // Bubble into Decode: explicit flush, wrong-path squash, or PC write in flight
    always_comb begin
        bubbleD = FlushD | redirect | (PCWrPendingF & ~StallD);
    end

    // IF/ID register; a bubble wins over a Decode stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (bubbleD) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
        end
    end

    // Decode fields handed to the controller straight from the IF/ID register
    assign TypeD            = InstrD[31:29];
    assign OpD              = InstrD[28:25];
    assign RegWriteAddressD = InstrD[24:20];

`ifdef FETCH_PERF_CNT_EN
    logic stallEvent;

    // A cycle counts as a stall only if the PC was held rather than redirected
    assign stallEvent = pcHold & ~redirect;

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
        end else if (stallEvent && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

    // Saturating Decode-bubble counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FlushCount <= '0;
        end else if (bubbleD && (FlushCount != {CNT_W{1'b1}})) begin
            FlushCount <= FlushCount + CNT_W'(1);
        end
    end
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written reset sequences and
// randomized hazards checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'hE2A0_0000;
    localparam logic [31:0] I1          = 32'h2000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCWrPendingF, BranchTakenE, PCSrcW;
    logic [31:0] BranchTargetE, ResultW;
    logic [31:0] PCF, InstrF, InstrD, PCPlus4D;
    logic        ValidD;
    logic [2:0]  TypeD;
    logic [3:0]  OpD;
    logic [4:0]  RegWriteAddressD;
    logic [15:0] StallCount, FlushCount;

    logic        useMem;
    int          errors = 0;
    int          checks = 0;

    fetch_stage #(.RESET_PC(TB_RESET_PC), .NOP_INSTR(TB_NOP)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCSrcW(PCSrcW), .ResultW(ResultW), .PCF(PCF), .InstrF(InstrF), .InstrD(InstrD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .TypeD(TypeD), .OpD(OpD),
        .RegWriteAddressD(RegWriteAddressD), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    // Instruction memory image: any address maps to a distinct word
    function automatic logic [31:0] memFn(input logic [31:0] a);
        return {a[7:0] ^ 8'h5C, a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    assign InstrF = useMem ? memFn(PCF) : I1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic sf, input logic sd, input logic fl, input logic pe,
                         input logic bt, input logic [31:0] bta, input logic ps,
                         input logic [31:0] rw);
        StallF = sf; StallD = sd; FlushD = fl; PCWrPendingF = pe;
        BranchTakenE = bt; BranchTargetE = bta; PCSrcW = ps; ResultW = rw;
    endtask

    task automatic chkResetVals(input string tag);
        chk({tag, ".PCF"}, PCF, TB_RESET_PC);
        chk({tag, ".InstrD"}, InstrD, TB_NOP);
        chk({tag, ".PCPlus4D"}, PCPlus4D, 32'h0);
        chk({tag, ".ValidD"}, 32'(ValidD), 32'h0);
        chk({tag, ".StallCount"}, 32'(StallCount), 32'h0);
        chk({tag, ".FlushCount"}, 32'(FlushCount), 32'h0);
    endtask

    typedef struct {
        logic        sf, sd, fl, pe, bt, ps;
        logic [31:0] bta, rw;
        logic [31:0] ePc, eInstr, ePc4;
        logic        eValid;
    } vec_t;

    function automatic vec_t mk(input logic sf, input logic sd, input logic fl, input logic pe,
                                input logic bt, input logic [31:0] bta, input logic ps,
                                input logic [31:0] rw, input logic [31:0] ePc,
                                input logic [31:0] eInstr, input logic [31:0] ePc4,
                                input logic eValid);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fl = fl; v.pe = pe; v.bt = bt; v.bta = bta;
        v.ps = ps; v.rw = rw; v.ePc = ePc; v.eInstr = eInstr; v.ePc4 = ePc4; v.eValid = eValid;
        return v;
    endfunction

    // Behavioural model state
    logic [31:0] mPc, mInstr, mPc4;
    logic        mValid;
    logic [15:0] mStall, mFlush;

    function automatic logic [15:0] satInc(input logic [15:0] c, input logic en);
        return (en && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    task automatic modelReset();
        mPc = TB_RESET_PC; mInstr = TB_NOP; mPc4 = 32'h0; mValid = 1'b0;
        mStall = 16'h0; mFlush = 16'h0;
    endtask

    // One clock of the fetch rules applied to the current inputs
    task automatic modelStep();
        logic        redir, bub;
        logic [31:0] tgt, fetched;
        redir   = BranchTakenE | PCSrcW;
        tgt     = BranchTakenE ? BranchTargetE : ResultW;
        bub     = FlushD | redir | (PCWrPendingF & ~StallD);
        fetched = memFn(mPc);
`ifdef FETCH_PERF_CNT_EN
        mStall = satInc(mStall, (StallF | PCWrPendingF) & ~redir);
        mFlush = satInc(mFlush, bub);
`endif
        if (bub) begin
            mInstr = TB_NOP; mPc4 = 32'h0; mValid = 1'b0;
        end else if (!StallD) begin
            mInstr = fetched; mPc4 = mPc + 32'd4; mValid = 1'b1;
        end
        if (redir)                       mPc = tgt;
        else if (!(StallF | PCWrPendingF)) mPc = mPc + 32'd4;
    endtask

    task automatic chkModel(input string tag);
        chk({tag, ".PCF"}, PCF, mPc);
        chk({tag, ".InstrD"}, InstrD, mInstr);
        chk({tag, ".PCPlus4D"}, PCPlus4D, mPc4);
        chk({tag, ".ValidD"}, 32'(ValidD), 32'(mValid));
        chk({tag, ".TypeD"}, 32'(TypeD), 32'(mInstr[31:29]));
        chk({tag, ".OpD"}, 32'(OpD), 32'(mInstr[28:25]));
        chk({tag, ".RegWrAddrD"}, 32'(RegWriteAddressD), 32'(mInstr[24:20]));
        chk({tag, ".StallCount"}, 32'(StallCount), 32'(mStall));
        chk({tag, ".FlushCount"}, 32'(FlushCount), 32'(mFlush));
    endtask

    vec_t vecs[14];
    int   expCnt;

    initial begin
        // Directed sequence from reset with InstrF fixed at I1
        vecs[0]  = mk(0,0,0,0, 0,32'h0,   0,32'h0,         32'h4,   I1,     32'h4,   1);
        vecs[1]  = mk(0,0,0,0, 0,32'h0,   0,32'h0,         32'h8,   I1,     32'h8,   1);
        vecs[2]  = mk(1,1,0,0, 0,32'h0,   0,32'h0,         32'h8,   I1,     32'h8,   1);
        vecs[3]  = mk(1,1,0,0, 0,32'h0,   0,32'h0,         32'h8,   I1,     32'h8,   1);
        vecs[4]  = mk(0,0,0,0, 0,32'h0,   0,32'h0,         32'hC,   I1,     32'hC,   1);
        vecs[5]  = mk(1,0,0,0, 1,32'h100, 0,32'h0,         32'h100, TB_NOP, 32'h0,   0);
        vecs[6]  = mk(0,0,0,0, 0,32'h0,   0,32'h0,         32'h104, I1,     32'h104, 1);
        vecs[7]  = mk(0,0,0,0, 1,32'h40,  1,32'h80,        32'h40,  TB_NOP, 32'h0,   0);
        vecs[8]  = mk(0,0,0,0, 0,32'h0,   1,32'hFFFF_FFFC, 32'hFFFF_FFFC, TB_NOP, 32'h0, 0);
        vecs[9]  = mk(0,0,0,0, 0,32'h0,   0,32'h0,         32'h0,   I1,     32'h0,   1);
        vecs[10] = mk(0,1,0,0, 0,32'h0,   0,32'h0,         32'h4,   I1,     32'h0,   1);
        vecs[11] = mk(0,1,1,0, 0,32'h0,   0,32'h0,         32'h8,   TB_NOP, 32'h0,   0);
        vecs[12] = mk(0,0,0,1, 0,32'h0,   0,32'h0,         32'h8,   TB_NOP, 32'h0,   0);
        vecs[13] = mk(0,0,0,0, 0,32'h0,   0,32'h0,         32'hC,   I1,     32'hC,   1);

        useMem = 1'b0;
        reset  = 1'b1;
        setIn(0,0,0,0, 0,32'h0, 0,32'h0);
        #3;
        chkResetVals("por");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            setIn(vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].pe,
                  vecs[i].bt, vecs[i].bta, vecs[i].ps, vecs[i].rw);
            tick();
            chk($sformatf("vec%0d.PCF", i), PCF, vecs[i].ePc);
            chk($sformatf("vec%0d.InstrD", i), InstrD, vecs[i].eInstr);
            chk($sformatf("vec%0d.PCPlus4D", i), PCPlus4D, vecs[i].ePc4);
            chk($sformatf("vec%0d.ValidD", i), 32'(ValidD), 32'(vecs[i].eValid));
            chk($sformatf("vec%0d.TypeD", i), 32'(TypeD), 32'(vecs[i].eInstr[31:29]));
            chk($sformatf("vec%0d.OpD", i), 32'(OpD), 32'(vecs[i].eInstr[28:25]));
        end

        // Async reset mid-cycle with a redirect pending; redirect must be discarded
        setIn(0,0,0,0, 1,32'h300, 1,32'h500);
        #2;
        reset = 1'b1;
        #1;
        chkResetVals("asyncRst1");
        tick();
        chkResetVals("rstHeld");
        setIn(0,0,0,0, 0,32'h0, 0,32'h0);
        @(negedge clk);
        reset = 1'b0;
        useMem = 1'b1;
        modelReset();
        #1;
        chk("firstFetch.PCF", PCF, TB_RESET_PC);

        // PC write in flight for three cycles, then reset mid-run
        setIn(0,0,0,1, 0,32'h0, 0,32'h0);
        for (int i = 0; i < 3; i++) begin
            modelStep();
            tick();
        end
`ifdef FETCH_PERF_CNT_EN
        expCnt = 3;
`else
        expCnt = 0;
`endif
        chk("pend3.StallCount", 32'(StallCount), 32'(expCnt));
        chk("pend3.FlushCount", 32'(FlushCount), 32'(expCnt));
        chk("pend3.PCF", PCF, TB_RESET_PC);
        setIn(0,0,0,0, 0,32'h0, 0,32'h0);
        #2;
        reset = 1'b1;
        #1;
        chkResetVals("asyncRst2");
        @(negedge clk);
        reset = 1'b0;
        modelReset();

        // Randomized hazards against the behavioural model
        for (int c = 0; c < 600; c++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            b = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            setIn($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, a, $urandom_range(0, 9) == 0, b);
            modelStep();
            tick();
            chkModel($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
